ase_pcie_ss_rd_tag_mapper: RTL and testbench



---
 rtl/ase_pcie_ss_rd_tag_mapper.sv | 135 +++++++++++++
 tb/tb_ase_pcie_ss_rd_tag_mapper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ase_pcie_ss_rd_tag_mapper.sv
// DMA read tag mapper: hands out internal tags (free-list remap or AFU pass-through),
// tracks busy tags and restores the AFU tag on the completion path.
module ase_pcie_ss_rd_tag_mapper #(
    parameter int MAX_OUTSTANDING    = 64,
    parameter int AFU_TAG_W          = 10,
    parameter int EMULATE_TAG_MAPPER = 1,
    localparam int TW                = $clog2(MAX_OUTSTANDING)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AFU_TAG_W-1:0] req_afu_tag,
    output logic [TW-1:0]        req_int_tag,
    input  logic                 cpl_valid,
    input  logic [TW-1:0]        cpl_int_tag,
    input  logic                 cpl_last,
    output logic                 cpl_out_valid,
    output logic [AFU_TAG_W-1:0] cpl_out_afu_tag,
    output logic                 cpl_out_last,
    output logic [TW:0]          outstanding,
    output logic                 err_unexpected_cpl
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                 state;
    logic [TW-1:0]          init_cnt;
    logic [MAX_OUTSTANDING-1:0] busy;
    logic [AFU_TAG_W-1:0]   tag_ram [MAX_OUTSTANDING];

    logic                   fl_empty;
    logic [TW-1:0]          fl_head;
    logic [TW-1:0]          tag_sel;
    logic                   can_issue;
    logic                   accept;
    logic                   cpl_busy;
    logic                   release_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= (EMULATE_TAG_MAPPER != 0) ? S_INIT : S_RUN;
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == TW'(MAX_OUTSTANDING - 1))
                state <= S_RUN;
        end
    end

    assign cpl_busy    = busy[cpl_int_tag];
    assign release_tag = cpl_valid && cpl_last && cpl_busy;

    generate
        if (EMULATE_TAG_MAPPER != 0) begin : g_remap
            logic [TW-1:0] fl_mem [MAX_OUTSTANDING];
            logic [TW-1:0] rd_ptr, wr_ptr;
            logic [TW:0]   fl_count;
            logic          push, pop;
            logic [TW-1:0] push_tag;

            // INIT seeds the list; afterwards only released (busy) tags come back,
            // so the list never holds more than MAX_OUTSTANDING entries.
            assign push     = (state == S_INIT) || release_tag;
            assign push_tag = (state == S_INIT) ? init_cnt : cpl_int_tag;
            assign pop      = accept;

            always_ff @(posedge clk) begin
                if (push)
                    fl_mem[wr_ptr] <= push_tag;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_ptr   <= '0;
                    wr_ptr   <= '0;
                    fl_count <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop)  rd_ptr <= rd_ptr + 1'b1;
                    fl_count <= fl_count + (TW+1)'(push) - (TW+1)'(pop);
                end
            end

            assign fl_empty  = (fl_count == '0);
            assign fl_head   = fl_mem[rd_ptr];
            assign tag_sel   = fl_head;
            assign can_issue = !fl_empty;
        end else begin : g_pass
            assign fl_empty  = 1'b1;
            assign fl_head   = '0;
            assign tag_sel   = req_afu_tag[TW-1:0];
            // Busy is registered, so a same-cycle release cannot unblock the duplicate.
            assign can_issue = !busy[tag_sel];
        end
    endgenerate

    assign req_ready   = !rst && (state == S_RUN) && can_issue;
    assign req_int_tag = req_ready ? tag_sel : '0;
    assign accept      = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (accept)
            tag_ram[tag_sel] <= req_afu_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (release_tag) busy[cpl_int_tag] <= 1'b0;
            if (accept)      busy[tag_sel]     <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpl_out_valid      <= 1'b0;
            cpl_out_afu_tag    <= '0;
            cpl_out_last       <= 1'b0;
            outstanding        <= '0;
            err_unexpected_cpl <= 1'b0;
        end else begin
            cpl_out_valid <= cpl_valid;
            if (cpl_valid) begin
                cpl_out_afu_tag <= tag_ram[cpl_int_tag];
                cpl_out_last    <= cpl_last;
                if (!cpl_busy)
                    err_unexpected_cpl <= 1'b1;
            end
            outstanding <= outstanding + (TW+1)'(accept) - (TW+1)'(release_tag);
        end
    end

endmodule

// File: tb/tb_ase_pcie_ss_rd_tag_mapper.sv
// Directed bench: remap instance and pass-through instance, 8 internal tags each.
module tb_ase_pcie_ss_rd_tag_mapper;

    localparam int MAXO = 8;
    localparam int ATW  = 10;
    localparam int TW   = 3;

    logic clk, rst;

    logic           r_req_valid, r_req_ready;
    logic [ATW-1:0] r_req_afu_tag;
    logic [TW-1:0]  r_req_int_tag;
    logic           r_cpl_valid, r_cpl_last;
    logic [TW-1:0]  r_cpl_int_tag;
    logic           r_cpl_out_valid, r_cpl_out_last, r_err;
    logic [ATW-1:0] r_cpl_out_afu_tag;
    logic [TW:0]    r_outstanding;

    logic           p_req_valid, p_req_ready;
    logic [ATW-1:0] p_req_afu_tag;
    logic [TW-1:0]  p_req_int_tag;
    logic           p_cpl_valid, p_cpl_last;
    logic [TW-1:0]  p_cpl_int_tag;
    logic           p_cpl_out_valid, p_cpl_out_last, p_err;
    logic [ATW-1:0] p_cpl_out_afu_tag;
    logic [TW:0]    p_outstanding;

    int nc = 0;
    int nf = 0;

    ase_pcie_ss_rd_tag_mapper #(.MAX_OUTSTANDING(MAXO), .AFU_TAG_W(ATW), .EMULATE_TAG_MAPPER(1)) u_remap (
        .clk(clk), .rst(rst),
        .req_valid(r_req_valid), .req_ready(r_req_ready),
        .req_afu_tag(r_req_afu_tag), .req_int_tag(r_req_int_tag),
        .cpl_valid(r_cpl_valid), .cpl_int_tag(r_cpl_int_tag), .cpl_last(r_cpl_last),
        .cpl_out_valid(r_cpl_out_valid), .cpl_out_afu_tag(r_cpl_out_afu_tag),
        .cpl_out_last(r_cpl_out_last), .outstanding(r_outstanding),
        .err_unexpected_cpl(r_err)
    );

    ase_pcie_ss_rd_tag_mapper #(.MAX_OUTSTANDING(MAXO), .AFU_TAG_W(ATW), .EMULATE_TAG_MAPPER(0)) u_pass (
        .clk(clk), .rst(rst),
        .req_valid(p_req_valid), .req_ready(p_req_ready),
        .req_afu_tag(p_req_afu_tag), .req_int_tag(p_req_int_tag),
        .cpl_valid(p_cpl_valid), .cpl_int_tag(p_cpl_int_tag), .cpl_last(p_cpl_last),
        .cpl_out_valid(p_cpl_out_valid), .cpl_out_afu_tag(p_cpl_out_afu_tag),
        .cpl_out_last(p_cpl_out_last), .outstanding(p_outstanding),
        .err_unexpected_cpl(p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        nc++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        r_req_valid = 0; r_req_afu_tag = '0; r_cpl_valid = 0; r_cpl_int_tag = '0; r_cpl_last = 0;
        p_req_valid = 0; p_req_afu_tag = '0; p_cpl_valid = 0; p_cpl_int_tag = '0; p_cpl_last = 0;
        repeat (2) tick();

        chk("rst_req_ready", 32'(r_req_ready), 0);
        chk("rst_req_int_tag", 32'(r_req_int_tag), 0);
        chk("rst_cpl_out_valid", 32'(r_cpl_out_valid), 0);
        chk("rst_cpl_out_afu_tag", 32'(r_cpl_out_afu_tag), 0);
        chk("rst_outstanding", 32'(r_outstanding), 0);
        chk("rst_err", 32'(r_err), 0);
        chk("rst_pt_ready", 32'(p_req_ready), 0);

        rst = 1'b0;
        #1;
        chk("pt_ready_after_rst", 32'(p_req_ready), 1);
        chk("init_ready_c0", 32'(r_req_ready), 0);
        for (int k = 1; k <= MAXO; k++) begin
            tick();
            chk($sformatf("init_ready_c%0d", k), 32'(r_req_ready), (k == MAXO) ? 1 : 0);
        end

        // Eight requests sharing one AFU tag take internal tags 0..7
        r_req_valid = 1; r_req_afu_tag = 10'h3A5;
        for (int i = 0; i < MAXO; i++) begin
            #1;
            chk($sformatf("acc%0d_ready", i), 32'(r_req_ready), 1);
            chk($sformatf("acc%0d_tag", i), 32'(r_req_int_tag), 32'(i));
            tick();
        end
        #1;
        chk("full_ready", 32'(r_req_ready), 0);
        chk("full_outstanding", 32'(r_outstanding), 8);

        r_cpl_valid = 1; r_cpl_int_tag = 3'd5; r_cpl_last = 1;
        tick();
        r_cpl_valid = 0; r_cpl_last = 0;
        #1;
        chk("cpl5_valid", 32'(r_cpl_out_valid), 1);
        chk("cpl5_afu_tag", 32'(r_cpl_out_afu_tag), 32'h3A5);
        chk("cpl5_last", 32'(r_cpl_out_last), 1);
        chk("cpl5_outstanding", 32'(r_outstanding), 7);
        chk("realloc5_ready", 32'(r_req_ready), 1);
        chk("realloc5_tag", 32'(r_req_int_tag), 5);
        tick();
        chk("realloc5_outstanding", 32'(r_outstanding), 8);
        chk("realloc5_ready_after", 32'(r_req_ready), 0);
        chk("cpl_valid_drops", 32'(r_cpl_out_valid), 0);

        // Release with empty free list: tag comes back only next cycle
        r_cpl_valid = 1; r_cpl_int_tag = 3'd2; r_cpl_last = 1;
        #1;
        chk("same_cyc_ready", 32'(r_req_ready), 0);
        tick();
        r_cpl_valid = 0; r_cpl_last = 0;
        #1;
        chk("same_cyc_outstanding", 32'(r_outstanding), 7);
        chk("same_cyc_next_ready", 32'(r_req_ready), 1);
        chk("same_cyc_next_tag", 32'(r_req_int_tag), 2);
        tick();
        r_req_valid = 0;
        #1;
        chk("same_cyc_final_outstanding", 32'(r_outstanding), 8);

        // Back-to-back last completions for tags 0, 1, 3
        r_cpl_valid = 1; r_cpl_last = 1; r_cpl_int_tag = 3'd0;
        tick();
        chk("b2b0_valid", 32'(r_cpl_out_valid), 1);
        r_cpl_int_tag = 3'd1;
        tick();
        chk("b2b1_valid", 32'(r_cpl_out_valid), 1);
        r_cpl_int_tag = 3'd3;
        tick();
        r_cpl_valid = 0; r_cpl_last = 0;
        #1;
        chk("b2b3_valid", 32'(r_cpl_out_valid), 1);
        chk("b2b_outstanding", 32'(r_outstanding), 5);
        tick();
        chk("b2b_valid_drops", 32'(r_cpl_out_valid), 0);

        r_cpl_valid = 1; r_cpl_int_tag = 3'd4; r_cpl_last = 0;
        tick();
        r_cpl_valid = 0;
        #1;
        chk("nonlast_outstanding", 32'(r_outstanding), 5);
        chk("nonlast_last", 32'(r_cpl_out_last), 0);
        chk("nonlast_afu_tag", 32'(r_cpl_out_afu_tag), 32'h3A5);

        // Tag 0 was already released: unexpected
        r_cpl_valid = 1; r_cpl_int_tag = 3'd0; r_cpl_last = 1;
        #1;
        chk("unexp_err_before", 32'(r_err), 0);
        tick();
        r_cpl_valid = 0; r_cpl_last = 0;
        #1;
        chk("unexp_err", 32'(r_err), 1);
        chk("unexp_outstanding", 32'(r_outstanding), 5);
        chk("unexp_forwarded", 32'(r_cpl_out_valid), 1);
        tick();
        chk("unexp_err_sticky", 32'(r_err), 1);

        rst = 1;
        #1;
        chk("midrst_outstanding", 32'(r_outstanding), 0);
        chk("midrst_err", 32'(r_err), 0);
        chk("midrst_ready", 32'(r_req_ready), 0);
        chk("midrst_cpl_valid", 32'(r_cpl_out_valid), 0);
        tick();
        rst = 0;
        for (int k = 1; k <= MAXO; k++) begin
            tick();
            chk($sformatf("reinit_ready_c%0d", k), 32'(r_req_ready), (k == MAXO) ? 1 : 0);
        end
        chk("reinit_tag", 32'(r_req_int_tag), 0);

        r_cpl_valid = 1; r_cpl_int_tag = 3'd3; r_cpl_last = 1;
        tick();
        r_cpl_valid = 0; r_cpl_last = 0;
        #1;
        chk("postrst_unexp_err", 32'(r_err), 1);
        chk("postrst_unexp_outstanding", 32'(r_outstanding), 0);
        repeat (3) tick();
        chk("postrst_err_sticky", 32'(r_err), 1);
        chk("postrst_outstanding_hold", 32'(r_outstanding), 0);

        // Pass-through duplicate stall
        p_req_valid = 1; p_req_afu_tag = 10'h204;
        #1;
        chk("pt_first_ready", 32'(p_req_ready), 1);
        chk("pt_first_tag", 32'(p_req_int_tag), 4);
        tick();
        chk("pt_outstanding1", 32'(p_outstanding), 1);
        chk("pt_dup_stall", 32'(p_req_ready), 0);

        p_cpl_valid = 1; p_cpl_int_tag = 3'd4; p_cpl_last = 0;
        tick();
        p_cpl_valid = 0;
        #1;
        chk("pt_nonlast_stall", 32'(p_req_ready), 0);
        chk("pt_nonlast_valid", 32'(p_cpl_out_valid), 1);
        chk("pt_nonlast_afu_tag", 32'(p_cpl_out_afu_tag), 32'h204);
        chk("pt_nonlast_last", 32'(p_cpl_out_last), 0);
        chk("pt_nonlast_outstanding", 32'(p_outstanding), 1);

        p_cpl_valid = 1; p_cpl_last = 1;
        #1;
        chk("pt_release_same_cyc", 32'(p_req_ready), 0);
        tick();
        p_cpl_valid = 0; p_cpl_last = 0;
        #1;
        chk("pt_release_next_ready", 32'(p_req_ready), 1);
        chk("pt_release_outstanding", 32'(p_outstanding), 0);
        chk("pt_release_last", 32'(p_cpl_out_last), 1);
        tick();
        p_req_valid = 0;
        #1;
        chk("pt_reaccept_outstanding", 32'(p_outstanding), 1);
        chk("pt_err_clear", 32'(p_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

endmodule
